alu_ctrl_idex: RTL and testbench
================================

// Module: alu_ctrl_idex
// PURPOSE
//  ID-stage ALU control decoder plus ID/EX pipeline register for the 5-stage RV32I core.
//  - Decodes the 32-bit instruction in Decode into the 5-bit ALU op code.
//  - Selects operand A/B: rs1, rs2, PC, immediate, zero or constant 4.
//  - Registers alu_opE, SrcAE and SrcBE into Execute, where the combinational ALU uses them.
//  - Honours the hazard unit's stall and flush.
// PARAMETERS
//  XLEN    32  datapath width; only 32 is supported
//  OPW     5   ALU op code width
// PORTS
//  clk        in   1     core clock; all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  validD     in   1     instrD holds a real instruction (0 = bubble from IF/ID)
//  instrD     in   32    instruction word in Decode
//  PCD        in   32    PC of instrD
//  RD1D       in   32    register file read data for rs1 (already forwarded)
//  RD2D       in   32    register file read data for rs2 (already forwarded)
//  stallE     in   1     hold ID/EX register contents
//  flushE     in   1     load a bubble into ID/EX
//  alu_opE    out  5     registered ALU op code
//  SrcAE      out  32    registered operand A
//  SrcBE      out  32    registered operand B
//  validE     out  1     Execute stage holds a real instruction
//  illegalE   out  1     Execute instruction is not a decodable RV32I ALU user
// BEHAVIOUR
//  ALU op codes:
//   00000 ADD   00001 SUB   00010 SLL   00011 SLT   00100 SLTU   00101 XOR
//   00110 SRL   00111 SRA   01000 OR    01001 AND   01010 PASSB
//  Immediates are sign-extended from bit 31:
//   I = instr[31:20]
//   S = {instr[31:25], instr[11:7]}
//   B/J are not needed here (the branch/jump target adder lives elsewhere)
//   U = {instr[31:12], 12'b0}
//  Decode by opcode (f3 = instr[14:12], f7 = instr[31:25]):
//   0110011 OP: f3 000 ADD/SUB (f7 = 0100000 -> SUB); 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//     101 SRL/SRA (f7 = 0100000 -> SRA); 110 OR; 111 AND.
//     A = RD1D, B = RD2D. f7 not 0000000 or 0100000, or 0100000 with f3 not 000/101 -> illegal.
//   0010011 OP-IMM: same f3 map, but 000 is always ADD. A = RD1D, B = I-imm.
//     f3 001: f7 must be 0000000. f3 101: f7 selects SRL/SRA as above. Any other f7 -> illegal.
//   0110111 LUI: PASSB, A = 0, B = U-imm.
//   0010111 AUIPC: ADD, A = PCD, B = U-imm.
//   0000011 LOAD: ADD, A = RD1D, B = I-imm.
//   0100011 STORE: ADD, A = RD1D, B = S-imm.
//   1100011 BRANCH: A = RD1D, B = RD2D. f3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU;
//     010/011 -> illegal.
//   1101111 JAL: ADD, A = PCD, B = 32'd4 (link value).
//   1100111 JALR: ADD, A = PCD, B = 32'd4. f3 not 000 -> illegal.
//   any other opcode -> illegal.
//  Illegal decode: alu_op = ADD, A = 0, B = 0, illegal = 1.
//  Register update per rising edge, priority order rst > flushE > stallE > load:
//   rst:        alu_opE = 0, SrcAE = 0, SrcBE = 0, validE = 0, illegalE = 0 (all outputs).
//   flushE:     same bubble values as reset, regardless of stallE.
//   stallE:     every output holds its previous value.
//   load:       if validD, capture the decoded values, validE = 1, illegalE = illegal flag.
//               if !validD, load the bubble (all zero).
//  Latency: exactly 1 cycle from instrD/RD*D to the E outputs.
//   No combinational path from any input to any output.
//  Reset mid-stall or mid-flush: rst wins; first cycle after rst deasserts behaves as load.
//  Stall held N cycles keeps the outputs constant for N cycles. The release cycle loads the current D.
// TESTING
//  1. rst = 1 with validD = 1, instr = ADD -> next cycle all outputs 0, validE = 0.
//  2. instr 0x40B50533 (sub x10,x10,x11), RD1D = 9, RD2D = 4
//     -> alu_opE = 00001, SrcAE = 9, SrcBE = 4, validE = 1.
//  3. instr 0x4041D193 (srai x3,x3,4), RD1D = 0x80000000
//     -> alu_opE = 00111, SrcBE = 0x00000404 (ALU uses bits [4:0] = 4).
//     Same with f7 = 0x7F -> illegalE = 1, A = B = 0.
//  4. instr 0x12345537 (lui) -> alu_opE = 01010, SrcAE = 0, SrcBE = 0x12345000.
//     auipc 0x00001097 with PCD = 0x100 -> ADD, SrcAE = 0x100, SrcBE = 0x1000.
//  5. Load bne RD1D = 3, RD2D = 3, then stallE = 1 for 3 cycles with new instrD
//     -> outputs hold SUB / 3 / 3. flushE = 1 and stallE = 1 together -> bubble next cycle.
//  6. jal with PCD = 0x200 -> ADD, SrcAE = 0x200, SrcBE = 4.
//     Opcode 0x7F -> illegalE = 1, validE = 1.
//     validD = 0 -> validE = 0.

Source files
------------

// File: rtl/alu_ctrl_idex.sv
// ID-stage ALU control decode and operand select,
// registered into Execute through the ID/EX pipeline register.
module alu_ctrl_idex #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validD,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic            stallE,
  input  logic            flushE,
  output logic [OPW-1:0]  alu_opE,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic            validE,
  output logic            illegalE
);

  localparam logic [OPW-1:0] ADD   = 5'd0;
  localparam logic [OPW-1:0] SUB   = 5'd1;
  localparam logic [OPW-1:0] SLL   = 5'd2;
  localparam logic [OPW-1:0] SLT   = 5'd3;
  localparam logic [OPW-1:0] SLTU  = 5'd4;
  localparam logic [OPW-1:0] XOR   = 5'd5;
  localparam logic [OPW-1:0] SRL   = 5'd6;
  localparam logic [OPW-1:0] SRA   = 5'd7;
  localparam logic [OPW-1:0] OR    = 5'd8;
  localparam logic [OPW-1:0] AND   = 5'd9;
  localparam logic [OPW-1:0] PASSB = 5'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            valid;
    logic            illegal;
  } id_ex_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [OPW-1:0]  f3_op;
  logic [OPW-1:0]  op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            ill;
  id_ex_t          nxt;
  id_ex_t          q;

  assign opc   = instrD[6:0];
  assign f3    = instrD[14:12];
  assign f7    = instrD[31:25];
  assign imm_i = {{20{instrD[31]}}, instrD[31:20]};
  assign imm_s = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
  assign imm_u = {instrD[31:12], 12'b0};

  always_comb begin
    f3_op = ADD;
    case (f3)
      3'b000:  f3_op = ADD;
      3'b001:  f3_op = SLL;
      3'b010:  f3_op = SLT;
      3'b011:  f3_op = SLTU;
      3'b100:  f3_op = XOR;
      3'b101:  f3_op = SRL;
      3'b110:  f3_op = OR;
      default: f3_op = AND;
    endcase
  end

  always_comb begin
    op  = ADD;
    a   = '0;
    b   = '0;
    ill = 1'b0;
    case (opc)
      OPC_OP: begin
        a  = RD1D;
        b  = RD2D;
        op = f3_op;
        if (f7 == F7_ALT && f3 == 3'b000) op = SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) op = SRA;
        else if (f7 != F7_ZERO) ill = 1'b1;
      end
      OPC_OPIMM: begin
        a  = RD1D;
        b  = imm_i;
        op = f3_op;
        if (f3 == 3'b001 && f7 != F7_ZERO) ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT) op = SRA;
          else if (f7 != F7_ZERO) ill = 1'b1;
        end
      end
      OPC_LUI: begin
        op = PASSB;
        b  = imm_u;
      end
      OPC_AUIPC: begin
        a = PCD;
        b = imm_u;
      end
      OPC_LOAD: begin
        a = RD1D;
        b = imm_i;
      end
      OPC_STORE: begin
        a = RD1D;
        b = imm_s;
      end
      OPC_BRANCH: begin
        a = RD1D;
        b = RD2D;
        case (f3[2:1])
          2'b00:   op = SUB;
          2'b10:   op = SLT;
          2'b11:   op = SLTU;
          default: ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        a = PCD;
        b = 32'd4;
      end
      OPC_JALR: begin
        a = PCD;
        b = 32'd4;
        if (f3 != 3'b000) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // illegal decodes feed a harmless ADD 0+0 into Execute
    if (ill) begin
      op = ADD;
      a  = '0;
      b  = '0;
    end
  end

  always_comb begin
    nxt = '0;
    if (validD) begin
      nxt.op      = op;
      nxt.a       = a;
      nxt.b       = b;
      nxt.valid   = 1'b1;
      nxt.illegal = ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          q <= '0;
    else if (flushE)  q <= '0;
    else if (!stallE) q <= nxt;
  end

  assign alu_opE  = q.op;
  assign SrcAE    = q.a;
  assign SrcBE    = q.b;
  assign validE   = q.valid;
  assign illegalE = q.illegal;

endmodule

// File: tb/tb_alu_ctrl_idex.sv
// Directed bench for alu_ctrl_idex: decode, operand select,
// stall/flush/reset priority on the ID/EX register.
module tb_alu_ctrl_idex;

  logic        clk = 1'b0;
  logic        rst;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic        stallE;
  logic        flushE;
  logic [4:0]  alu_opE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        validE;
  logic        illegalE;

  logic [70:0] got;
  logic [70:0] exp_v;
  int errors = 0;
  int checks = 0;

  alu_ctrl_idex dut (
    .clk(clk), .rst(rst), .validD(validD), .instrD(instrD),
    .PCD(PCD), .RD1D(RD1D), .RD2D(RD2D),
    .stallE(stallE), .flushE(flushE),
    .alu_opE(alu_opE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .validE(validE), .illegalE(illegalE)
  );

  always #5 clk = ~clk;

  assign got = {alu_opE, SrcAE, SrcBE, validE, illegalE};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; validD = 1'b1; instrD = 32'h00B50533;
    PCD = 32'h40; RD1D = 32'd7; RD2D = 32'd8;
    stallE = 1'b0; flushE = 1'b0;
    step();
    exp_v = {5'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL reset got=%h want=%h", got, exp_v);
    end
    rst = 1'b0;
    step();
    exp_v = {5'd0, 32'd7, 32'd8, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL add_after_reset got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_op();
    instrD = 32'h40B50533; RD1D = 32'd9; RD2D = 32'd4;
    step();
    exp_v = {5'd1, 32'd9, 32'd4, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL sub got=%h want=%h", got, exp_v);
    end
    // and x1,x2,x3 with bad f7 0000001 (mul) -> illegal
    instrD = 32'h023170B3;
    step();
    exp_v = {5'd0, 32'd0, 32'd0, 1'b1, 1'b1};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL op_bad_f7 got=%h want=%h", got, exp_v);
    end
    // sra x1,x2,x3
    instrD = 32'h403150B3; RD1D = 32'hF0; RD2D = 32'd2;
    step();
    exp_v = {5'd7, 32'hF0, 32'd2, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL sra got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_op_imm();
    instrD = 32'h4041D193; RD1D = 32'h80000000;
    step();
    exp_v = {5'd7, 32'h80000000, 32'h00000404, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL srai got=%h want=%h", got, exp_v);
    end
    instrD = 32'hFE41D193;
    step();
    exp_v = {5'd0, 32'd0, 32'd0, 1'b1, 1'b1};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL srai_bad_f7 got=%h want=%h", got, exp_v);
    end
    // addi x1,x2,-1: f7 bits are immediate, still ADD
    instrD = 32'hFFF10093; RD1D = 32'd5;
    step();
    exp_v = {5'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL addi_neg got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_mem_upper();
    instrD = 32'h12345537;
    step();
    exp_v = {5'd10, 32'd0, 32'h12345000, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL lui got=%h want=%h", got, exp_v);
    end
    instrD = 32'h00001097; PCD = 32'h100;
    step();
    exp_v = {5'd0, 32'h100, 32'h1000, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL auipc got=%h want=%h", got, exp_v);
    end
    // sw x5,-4(x6): S-imm = 0xFFC sign-extended
    instrD = 32'hFE532E23; RD1D = 32'h1000;
    step();
    exp_v = {5'd0, 32'h1000, 32'hFFFFFFFC, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL store got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_stall_flush();
    // bne x3,x3,8
    instrD = 32'h00319463; RD1D = 32'd3; RD2D = 32'd3;
    step();
    exp_v = {5'd1, 32'd3, 32'd3, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL bne got=%h want=%h", got, exp_v);
    end
    stallE = 1'b1; instrD = 32'h12345537; RD1D = 32'd99;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL stall_hold%0d got=%h want=%h", i, got, exp_v);
      end
    end
    flushE = 1'b1;
    step();
    exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL flush_over_stall got=%h want=%h", got, exp_v);
    end
    flushE = 1'b0; stallE = 1'b0;
    step();
    exp_v = {5'd10, 32'd0, 32'h12345000, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL release_load got=%h want=%h", got, exp_v);
    end
    // branch f3 010 is not a branch
    instrD = 32'h0031A463;
    step();
    exp_v = {5'd0, 32'd0, 32'd0, 1'b1, 1'b1};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL branch_f3_010 got=%h want=%h", got, exp_v);
    end
    // bltu x3,x3 -> SLTU
    instrD = 32'h0031E463; RD1D = 32'd3;
    step();
    exp_v = {5'd4, 32'd3, 32'd3, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL bltu got=%h want=%h", got, exp_v);
    end
    stallE = 1'b1; rst = 1'b1;
    step();
    exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL rst_mid_stall got=%h want=%h", got, exp_v);
    end
    rst = 1'b0; stallE = 1'b0;
    step();
    exp_v = {5'd4, 32'd3, 32'd3, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL after_rst_load got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_jump_illegal();
    instrD = 32'h0000006F; PCD = 32'h200;
    step();
    exp_v = {5'd0, 32'h200, 32'd4, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL jal got=%h want=%h", got, exp_v);
    end
    // jalr with f3 001 -> illegal
    instrD = 32'h000090E7;
    step();
    exp_v = {5'd0, 32'd0, 32'd0, 1'b1, 1'b1};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL jalr_bad_f3 got=%h want=%h", got, exp_v);
    end
    instrD = 32'h0000007F;
    step();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL opcode_7f got=%h want=%h", got, exp_v);
    end
    validD = 1'b0; instrD = 32'h0000006F;
    step();
    exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL not_valid got=%h want=%h", got, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_op();
    test_op_imm();
    test_mem_upper();
    test_stall_flush();
    test_jump_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
